// File: rtl/data_mem_bytelane.sv
// Byte-addressable RV32 data memory with LB/LH/LW/LBU/LHU and SB/SH/SW byte lanes.
// Latency: loads combinational in the same cycle; word-crossing accesses take two cycles.
// Backpressure: stall is high for the first cycle of a crossing access; the core holds its inputs.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   memwrite, memread   store / load request (store wins when both are high)
//   funct3              RV32 access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, write_data    byte address, right-aligned store data
//   memdata_out         extended load result (0 when no load result is presented)
//   stall, err          combinational: hold-core request, illegal funct3 / misaligned trap
//
// Build option: define DMEM_MISALIGN_TRAP_EN to flag every misaligned H/W access with err
// instead of splitting it; in that build the SPLIT state does not exist.
module data_mem_bytelane #(
    parameter int DEPTH       = 64,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] memdata_out,
    output logic        stall,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] r_mem [DEPTH];

    // Request decode on the live inputs (only meaningful outside SPLIT)
    logic          w_req;
    logic          w_illegal;
    logic          w_mis;
    logic          w_cross;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    assign w_req         = memread | memwrite;
    assign w_illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign w_idx         = addr[AW+1:2];
    // Upper address bits alias onto the array
    assign w_unused_addr = ^addr[31:AW+2];

    // Effective access parameters: live inputs in IDLE, latched values in SPLIT
    logic          w_split;
    logic          w_split_we;
    logic [2:0]    w_f3;
    logic [1:0]    w_lane;
    logic [31:0]   w_wdat;
    logic [AW-1:0] w_hi_idx;
    logic [31:0]   w_lo_word;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis      = w_req && !w_illegal &&
                        (((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
    assign w_cross    = 1'b0;
    assign w_split    = 1'b0;
    assign w_split_we = 1'b0;
    assign w_f3       = funct3;
    assign w_lane     = addr[1:0];
    assign w_wdat     = write_data;
    assign w_hi_idx   = w_idx + AW'(1);
    assign w_lo_word  = r_mem[w_idx];
`else
    typedef enum logic {IDLE, SPLIT} state_t;

    state_t        r_state;
    logic [2:0]    r_f3;
    logic [1:0]    r_lane;
    logic [31:0]   r_wdat;
    logic          r_we;
    logic [AW-1:0] r_hi_idx;
    logic [31:0]   r_lo_word;

    assign w_mis   = 1'b0;
    // Halfword at lane 1 stays inside the word; only lane 3 crosses
    assign w_cross = w_req && !w_illegal &&
                     (((funct3[1:0] == 2'b01) && (addr[1:0] == 2'b11)) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));

    assign w_split    = (r_state == SPLIT);
    assign w_split_we = r_we;
    assign w_f3       = w_split ? r_f3      : funct3;
    assign w_lane     = w_split ? r_lane    : addr[1:0];
    assign w_wdat     = w_split ? r_wdat    : write_data;
    assign w_hi_idx   = w_split ? r_hi_idx  : w_idx + AW'(1);
    // Low word is captured at the first edge so a store in the same slot cannot disturb it
    assign w_lo_word  = w_split ? r_lo_word : r_mem[w_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_f3      <= '0;
            r_lane    <= '0;
            r_wdat    <= '0;
            r_we      <= 1'b0;
            r_hi_idx  <= '0;
            r_lo_word <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cross) begin
                        r_state   <= SPLIT;
                        r_f3      <= funct3;
                        r_lane    <= addr[1:0];
                        r_wdat    <= write_data;
                        r_we      <= memwrite;
                        r_hi_idx  <= w_idx + AW'(1);
                        r_lo_word <= r_mem[w_idx];
                    end
                end
                SPLIT:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
`endif

    // Load path: view the two-word window shifted down by the lane, then extend
    logic [31:0] w_hi_word;
    logic [63:0] w_raw64;
    logic [31:0] w_raw;
    logic [31:0] w_ext;

    assign w_hi_word = r_mem[w_hi_idx];
    assign w_raw64   = {w_hi_word, w_lo_word} >> {w_lane, 3'b000};
    assign w_raw     = w_raw64[31:0];

    always_comb begin
        case (w_f3[1:0])
            2'b00:   w_ext = {{24{w_raw[7]  & ~w_f3[2]}}, w_raw[7:0]};
            2'b01:   w_ext = {{16{w_raw[15] & ~w_f3[2]}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    // Store path: lane-shifted data/enables across two words; low half in IDLE, high half in SPLIT
    logic [3:0]    w_mask4;
    logic [7:0]    w_be8;
    logic [63:0]   w_sdat64;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic [3:0]    w_wr_be;
    logic [31:0]   w_wr_dat;

    assign w_mask4  = (w_f3[1:0] == 2'b00) ? 4'b0001 :
                      (w_f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign w_be8    = {4'b0000, w_mask4} << w_lane;
    assign w_sdat64 = {32'h0, w_wdat} << {w_lane, 3'b000};

    // Gating on reset matters for RESET_CLEAR=0: a reset in SPLIT drops the second half
    assign w_wr_en  = !reset && (w_split ? w_split_we
                                         : (memwrite && !w_illegal && !w_mis));
    assign w_wr_idx = w_split ? w_hi_idx        : w_idx;
    assign w_wr_be  = w_split ? w_be8[7:4]      : w_be8[3:0];
    assign w_wr_dat = w_split ? w_sdat64[63:32] : w_sdat64[31:0];

    generate
        if (RESET_CLEAR) begin : g_clear
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                end else if (w_wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wr_be[b]) begin
                            r_mem[w_wr_idx][8*b +: 8] <= w_wr_dat[8*b +: 8];
                        end
                    end
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (w_wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wr_be[b]) begin
                            r_mem[w_wr_idx][8*b +: 8] <= w_wr_dat[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    // Outputs: zero during reset; in SPLIT live inputs are ignored
    always_comb begin
        memdata_out = '0;
        stall       = 1'b0;
        err         = 1'b0;
        if (!reset) begin
            if (w_split) begin
                if (!w_split_we) begin
                    memdata_out = w_ext;
                end
            end else begin
                stall = w_cross;
                err   = w_req && (w_illegal || w_mis);
                if (memread && !memwrite && !w_illegal && !w_mis && !w_cross) begin
                    memdata_out = w_ext;
                end
            end
        end
    end

endmodule
